// File: rtl/ysyx_22040759_lsu_if.sv
// Bundle of the upstream request/response handshake and the memory port
// of the load/store unit. The LSU takes the slave view; the execute stage
// and the memory model together take the master view.
interface ysyx_22040759_lsu_if #(
    parameter int XLEN = 64,
    parameter int AW   = 64
);
    localparam int NB = XLEN / 8;

    logic            req_valid;
    logic            req_ready;
    logic            req_wen;
    logic [2:0]      req_func3;
    logic [AW-1:0]   req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_req_wen;
    logic [AW-1:0]   mem_req_addr;
    logic [XLEN-1:0] mem_req_wdata;
    logic [NB-1:0]   mem_req_wmask;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_wen, req_func3, req_addr, req_wdata,
        input  resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask
    );

    modport master (
        output req_valid, req_wen, req_func3, req_addr, req_wdata,
        output resp_ready,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask
    );
endinterface

// File: rtl/ysyx_22040759_lsu.sv
// Load/store unit: decodes funct3 into byte lanes, flags misaligned or
// width-illegal accesses, and runs one memory transaction at a time
// through IDLE -> REQ -> WAIT -> RESP. Every output is a flop.
module ysyx_22040759_lsu #(
    parameter int XLEN = 64,
    parameter int AW   = 64
) (
    input logic clk,
    input logic rst_n,
    ysyx_22040759_lsu_if.slave bus
);
    localparam int NB   = XLEN / 8;
    localparam int LGNB = $clog2(NB);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    state_t          r_state;
    logic            r_wen;
    logic [2:0]      r_func3;
    logic [LGNB-1:0] r_offset;
    logic            r_reqReady;
    logic            r_respValid;
    logic [XLEN-1:0] r_respRdata;
    logic            r_respErr;
    logic            r_memReqValid;
    logic            r_memReqWen;
    logic [AW-1:0]   r_memReqAddr;
    logic [XLEN-1:0] r_memReqWdata;
    logic [NB-1:0]   r_memReqWmask;

    logic [2:0]      w_alignMask;
    logic [3:0]      w_sizeBytes;
    logic            w_misaligned;
    logic            w_illegal;
    logic            w_err;
    logic [LGNB-1:0] w_offset;
    logic [NB-1:0]   w_lowBytes;
    logic [NB-1:0]   w_wmask;
    logic [XLEN-1:0] w_byteBits;
    logic [XLEN-1:0] w_wdataLane;
    logic [AW-1:0]   w_alignedAddr;

    logic [6:0]             w_dropBits;
    logic [XLEN-1:0]        w_rdShifted;
    logic [XLEN-1:0]        w_rdLeft;
    logic [XLEN-1:0]        w_rdZext;
    logic signed [XLEN-1:0] w_rdSext;
    logic [XLEN-1:0]        w_loadData;

    assign w_offset      = bus.req_addr[LGNB-1:0];
    assign w_alignedAddr = {bus.req_addr[AW-1:LGNB], {LGNB{1'b0}}};

    // Decode the incoming request: access size, alignment and legality,
    // plus the lane-shifted byte mask and store data that go to memory.
    always_comb begin
        w_alignMask = 3'b000;
        w_sizeBytes = 4'd1;
        case (bus.req_func3[1:0])
            2'b00: begin
                w_alignMask = 3'b000;
                w_sizeBytes = 4'd1;
            end
            2'b01: begin
                w_alignMask = 3'b001;
                w_sizeBytes = 4'd2;
            end
            2'b10: begin
                w_alignMask = 3'b011;
                w_sizeBytes = 4'd4;
            end
            default: begin
                w_alignMask = 3'b111;
                w_sizeBytes = 4'd8;
            end
        endcase
        w_misaligned = |(bus.req_addr[2:0] & w_alignMask);
        w_illegal    = (bus.req_func3 == 3'b111)
                     | (bus.req_wen & bus.req_func3[2])
                     | ((XLEN == 32) && (bus.req_func3[1:0] == 2'b11))
                     | ((XLEN == 32) && (bus.req_func3 == 3'b110));
        w_err        = w_misaligned | w_illegal;
        w_lowBytes   = '0;
        w_byteBits   = '0;
        for (int b = 0; b < NB; b++) begin
            w_lowBytes[b]       = (b < int'(w_sizeBytes));
            w_byteBits[8*b +: 8] = {8{b < int'(w_sizeBytes)}};
        end
        w_wmask     = w_lowBytes << w_offset;
        w_wdataLane = (bus.req_wdata & w_byteBits) << {w_offset, 3'b000};
    end

    // Pull the addressed lane out of the returned word, then sign- or
    // zero-extend by pushing it to the top and shifting it back down.
    always_comb begin
        case (r_func3[1:0])
            2'b00:   w_dropBits = 7'(XLEN - 8);
            2'b01:   w_dropBits = 7'(XLEN - 16);
            2'b10:   w_dropBits = 7'(XLEN - 32);
            default: w_dropBits = 7'd0;
        endcase
        w_rdShifted = bus.mem_rdata >> {r_offset, 3'b000};
        w_rdLeft    = w_rdShifted << w_dropBits;
        w_rdZext    = w_rdLeft >> w_dropBits;
        w_rdSext    = $signed(w_rdLeft) >>> w_dropBits;
        w_loadData  = r_func3[2] ? w_rdZext : $unsigned(w_rdSext);
    end

    // Transaction sequencer; erroneous accesses skip memory entirely and
    // responses are cleared once the upstream takes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_wen         <= 1'b0;
            r_func3       <= 3'b000;
            r_offset      <= '0;
            r_reqReady    <= 1'b1;
            r_respValid   <= 1'b0;
            r_respRdata   <= '0;
            r_respErr     <= 1'b0;
            r_memReqValid <= 1'b0;
            r_memReqWen   <= 1'b0;
            r_memReqAddr  <= '0;
            r_memReqWdata <= '0;
            r_memReqWmask <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_wen      <= bus.req_wen;
                        r_func3    <= bus.req_func3;
                        r_offset   <= w_offset;
                        r_reqReady <= 1'b0;
                        if (w_err) begin
                            r_respValid <= 1'b1;
                            r_respErr   <= 1'b1;
                            r_respRdata <= '0;
                            r_state     <= RESP;
                        end else begin
                            r_memReqValid <= 1'b1;
                            r_memReqWen   <= bus.req_wen;
                            r_memReqAddr  <= w_alignedAddr;
                            r_memReqWdata <= bus.req_wen ? w_wdataLane : '0;
                            r_memReqWmask <= bus.req_wen ? w_wmask : '0;
                            r_state       <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        r_memReqValid <= 1'b0;
                        r_state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_resp_valid) begin
                        r_respValid <= 1'b1;
                        r_respErr   <= 1'b0;
                        r_respRdata <= r_wen ? '0 : w_loadData;
                        r_state     <= RESP;
                    end
                end
                default: begin
                    if (bus.resp_ready) begin
                        r_respValid <= 1'b0;
                        r_respRdata <= '0;
                        r_respErr   <= 1'b0;
                        r_reqReady  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.req_ready     = r_reqReady;
    assign bus.resp_valid    = r_respValid;
    assign bus.resp_rdata    = r_respRdata;
    assign bus.resp_err      = r_respErr;
    assign bus.mem_req_valid = r_memReqValid;
    assign bus.mem_req_wen   = r_memReqWen;
    assign bus.mem_req_addr  = r_memReqAddr;
    assign bus.mem_req_wdata = r_memReqWdata;
    assign bus.mem_req_wmask = r_memReqWmask;
endmodule
